// File: rtl/operand_fetch.sv
// Operand-fetch stage: drives register-file read addresses, bypasses same-cycle
// writeback, stalls on RAW/WAW hazards via a per-register pending scoreboard.
module operand_fetch #(
  parameter int WIDTH_ADDR = 5,
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_PC   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH_PC-1:0]   in_pc,
  input  logic [WIDTH_ADDR-1:0] in_rs1,
  input  logic [WIDTH_ADDR-1:0] in_rs2,
  input  logic                  in_rs1_en,
  input  logic                  in_rs2_en,
  input  logic [WIDTH_ADDR-1:0] in_rd,
  input  logic                  in_rd_we,
  output logic [WIDTH_ADDR-1:0] rf_rd_addr1,
  output logic [WIDTH_ADDR-1:0] rf_rd_addr2,
  input  logic [WIDTH_DATA-1:0] rf_rd_data1,
  input  logic [WIDTH_DATA-1:0] rf_rd_data2,
  input  logic                  wb_valid,
  input  logic [WIDTH_ADDR-1:0] wb_rd,
  input  logic [WIDTH_DATA-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH_PC-1:0]   out_pc,
  output logic [WIDTH_DATA-1:0] out_rs1_data,
  output logic [WIDTH_DATA-1:0] out_rs2_data,
  output logic [WIDTH_ADDR-1:0] out_rd,
  output logic                  out_rd_we
);

  localparam int NREG = 1 << WIDTH_ADDR;

  logic [NREG-1:0]       pending_q, pending_d;
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH_PC-1:0]   out_pc_q, out_pc_d;
  logic [WIDTH_DATA-1:0] out_rs1_data_q, out_rs1_data_d;
  logic [WIDTH_DATA-1:0] out_rs2_data_q, out_rs2_data_d;
  logic [WIDTH_ADDR-1:0] out_rd_q, out_rd_d;
  logic                  out_rd_we_q, out_rd_we_d;

  logic                  src1_zero, src2_zero;
  logic                  wb_hit1, wb_hit2, wb_hit_rd;
  logic                  src1_ok, src2_ok, dst_ok;
  logic                  rd_we_eff;
  logic                  hazard, fire;
  logic [WIDTH_DATA-1:0] opnd1, opnd2;

  assign rf_rd_addr1 = in_rs1;
  assign rf_rd_addr2 = in_rs2;

  // Operand resolution and hazard detection. Writeback to the register being
  // read both supplies the data and retires the pending bit this cycle.
  always_comb begin
    src1_zero = !in_rs1_en || (in_rs1 == '0);
    src2_zero = !in_rs2_en || (in_rs2 == '0);
    wb_hit1   = wb_valid && (wb_rd == in_rs1);
    wb_hit2   = wb_valid && (wb_rd == in_rs2);
    wb_hit_rd = wb_valid && (wb_rd == in_rd);
    rd_we_eff = in_rd_we && (in_rd != '0);

    opnd1 = src1_zero ? '0 : (wb_hit1 ? wb_data : rf_rd_data1);
    opnd2 = src2_zero ? '0 : (wb_hit2 ? wb_data : rf_rd_data2);

    src1_ok = src1_zero || !pending_q[in_rs1] || wb_hit1;
    src2_ok = src2_zero || !pending_q[in_rs2] || wb_hit2;
    dst_ok  = !rd_we_eff || !pending_q[in_rd] || wb_hit_rd;
    hazard  = in_valid && !(src1_ok && src2_ok && dst_ok);
  end

  // Handshake: a transfer happens on a cycle where valid && ready are both
  // high at the rising edge; a producer holds its payload while valid && !ready.
  assign in_ready = !rst && !hazard && (!out_valid_q || out_ready);
  assign fire     = in_valid && in_ready;

  // Scoreboard: clear on writeback first, then set for the new writer so a
  // same-index set/clear leaves the bit set.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid && (wb_rd != '0)) begin
      pending_d[wb_rd] = 1'b0;
    end
    if (fire && rd_we_eff) begin
      pending_d[in_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    out_valid_d    = out_valid_q;
    out_pc_d       = out_pc_q;
    out_rs1_data_d = out_rs1_data_q;
    out_rs2_data_d = out_rs2_data_q;
    out_rd_d       = out_rd_q;
    out_rd_we_d    = out_rd_we_q;
    if (fire) begin
      out_valid_d    = 1'b1;
      out_pc_d       = in_pc;
      out_rs1_data_d = opnd1;
      out_rs2_data_d = opnd2;
      out_rd_d       = in_rd;
      out_rd_we_d    = rd_we_eff;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q      <= '0;
      out_valid_q    <= 1'b0;
      out_pc_q       <= '0;
      out_rs1_data_q <= '0;
      out_rs2_data_q <= '0;
      out_rd_q       <= '0;
      out_rd_we_q    <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      out_valid_q    <= out_valid_d;
      out_pc_q       <= out_pc_d;
      out_rs1_data_q <= out_rs1_data_d;
      out_rs2_data_q <= out_rs2_data_d;
      out_rd_q       <= out_rd_d;
      out_rd_we_q    <= out_rd_we_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_rs1_data = out_rs1_data_q;
  assign out_rs2_data = out_rs2_data_q;
  assign out_rd       = out_rd_q;
  assign out_rd_we    = out_rd_we_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, issue, RAW bypass, x0, backpressure,
// same-cycle set/clear, WAW and mid-operation reset.
module tb_operand_fetch;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rs1_en, in_rs2_en, in_rd_we;
  logic [4:0]  rf_rd_addr1, rf_rd_addr2;
  logic [31:0] rf_rd_data1, rf_rd_data2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data;
  logic [4:0]  out_rd;
  logic        out_rd_we;

  int vec_cnt  = 0;
  int fail_cnt = 0;

  operand_fetch #(.WIDTH_ADDR(5), .WIDTH_DATA(32), .WIDTH_PC(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_rd_we(out_rd_we)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_instr(input logic [31:0] pc,
                             input logic [4:0] rs1, input logic rs1_en,
                             input logic [4:0] rs2, input logic rs2_en,
                             input logic [4:0] rd, input logic rd_we);
    in_valid  = 1'b1;
    in_pc     = pc;
    in_rs1    = rs1;
    in_rs1_en = rs1_en;
    in_rs2    = rs2;
    in_rs2_en = rs2_en;
    in_rd     = rd;
    in_rd_we  = rd_we;
  endtask

  task automatic drop_instr();
    in_valid  = 1'b0;
    in_pc     = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_rd     = '0;
    in_rs1_en = 1'b0;
    in_rs2_en = 1'b0;
    in_rd_we  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [4:0] rd, input logic we);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".pc"}, out_pc, pc);
    chk({tag, ".rs1"}, out_rs1_data, d1);
    chk({tag, ".rs2"}, out_rs2_data, d2);
    chk({tag, ".rd"}, {27'd0, out_rd}, {27'd0, rd});
    chk({tag, ".we"}, {31'd0, out_rd_we}, {31'd0, we});
  endtask

  task automatic chk_ready(input string tag, input logic exp);
    chk(tag, {31'd0, in_ready}, {31'd0, exp});
  endtask

  initial begin
    rst = 1'b1;
    drop_instr();
    rf_rd_data1 = '0;
    rf_rd_data2 = '0;
    wb_valid    = 1'b0;
    wb_rd       = '0;
    wb_data     = '0;
    out_ready   = 1'b1;

    // Reset: outputs cleared, in_ready low even with a harmless instruction offered
    tick();
    drive_instr(32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk_ready("rst_in_ready", 1'b0);
    tick();
    chk_out("reset", 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    rst = 1'b0;
    drop_instr();
    tick();

    // Basic issue: rs1=3 rs2=4 rd=5
    drive_instr(32'h100, 5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1);
    rf_rd_data1 = 32'h11;
    rf_rd_data2 = 32'h22;
    #1;
    chk("rf_addr1", {27'd0, rf_rd_addr1}, 32'd3);
    chk("rf_addr2", {27'd0, rf_rd_addr2}, 32'd4);
    chk_ready("issue_ready", 1'b1);
    tick();
    drop_instr();
    chk_out("issue", 1'b1, 32'h100, 32'h11, 32'h22, 5'd5, 1'b1);

    // RAW stall on r5, resolved by writeback bypass
    drive_instr(32'h104, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
    rf_rd_data1 = 32'h55;
    #1;
    chk_ready("raw_stall0", 1'b0);
    tick();
    chk_ready("raw_stall1", 1'b0);
    chk("raw_drain_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk_ready("raw_stall2", 1'b0);
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    wb_data  = 32'hDEAD;
    #1;
    chk_ready("raw_release", 1'b1);
    tick();
    wb_valid = 1'b0;
    drop_instr();
    chk_out("raw", 1'b1, 32'h104, 32'hDEAD, 32'h0, 5'd6, 1'b1);

    // x0: operands forced to 0, rd_we squashed
    drive_instr(32'h108, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    rf_rd_data1 = 32'hFFFF_FFFF;
    rf_rd_data2 = 32'hFFFF_FFFF;
    #1;
    chk_ready("x0_ready", 1'b1);
    tick();
    chk_out("x0", 1'b1, 32'h108, 32'h0, 32'h0, 5'd0, 1'b0);
    // Writeback to x0 must not clear anything: r6 still pending
    drive_instr(32'h10C, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    wb_valid = 1'b1;
    wb_rd    = 5'd0;
    wb_data  = 32'h1234;
    #1;
    chk_ready("wb_x0_no_effect", 1'b0);

    // Backpressure: hold 0x108 bundle for 3 cycles; writeback retires r6
    out_ready = 1'b0;
    drive_instr(32'h110, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1);
    rf_rd_data1 = 32'hA1;
    rf_rd_data2 = 32'hA2;
    wb_rd       = 5'd6;
    wb_data     = 32'h66;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_ready("bp_ready", 1'b0);
      tick();
      wb_valid = 1'b0;
      chk_out("bp_hold", 1'b1, 32'h108, 32'h0, 32'h0, 5'd0, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk_ready("bp_release", 1'b1);
    tick();
    chk_out("bp_next", 1'b1, 32'h110, 32'hA1, 32'hA2, 5'd8, 1'b1);

    // Same-cycle set/clear on r7
    drive_instr(32'h114, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    tick();
    chk("r7_writer_pc", out_pc, 32'h114);
    drive_instr(32'h118, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
    rf_rd_data1 = 32'h70;
    wb_valid    = 1'b1;
    wb_rd       = 5'd7;
    wb_data     = 32'h77;
    #1;
    chk_ready("setclr_ready", 1'b1);
    tick();
    wb_valid = 1'b0;
    chk_out("setclr", 1'b1, 32'h118, 32'h77, 32'h0, 5'd7, 1'b1);
    drive_instr(32'h11C, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk_ready("setclr_raw0", 1'b0);
    tick();
    chk_ready("setclr_raw1", 1'b0);
    // WAW on pending r8
    drive_instr(32'h11C, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1);
    #1;
    chk_ready("waw_stall", 1'b0);
    tick();
    drop_instr();
    tick();

    // Back-to-back writers of r2 and r9, then reset mid-operation
    drive_instr(32'h120, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1);
    #1;
    chk_ready("b2b_ready0", 1'b1);
    tick();
    chk("b2b_pc0", out_pc, 32'h120);
    drive_instr(32'h124, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    #1;
    chk_ready("b2b_ready1", 1'b1);
    tick();
    chk("b2b_pc1", out_pc, 32'h124);
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    drop_instr();
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk_ready("midrst_ready", 1'b0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk_out("midrst", 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);

    // After reset r9/r2 are free; writeback to non-pending r2 is still bypassed
    drive_instr(32'h128, 5'd9, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1);
    rf_rd_data1 = 32'h99;
    rf_rd_data2 = 32'h22;
    wb_valid    = 1'b1;
    wb_rd       = 5'd2;
    wb_data     = 32'hBEEF;
    #1;
    chk_ready("post_rst_ready", 1'b1);
    tick();
    wb_valid = 1'b0;
    drop_instr();
    chk_out("post_rst", 1'b1, 32'h128, 32'h99, 32'hBEEF, 5'd9, 1'b1);
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule
